// File: rtl/frequency_result_reader.sv
// Reads REGISTERS_NUMBER consecutive result registers over AXI4-Lite on every irq rising edge.
// Define FREQUENCY_RESULT_READER_TIMEOUT_EN to enable the AR/R handshake watchdog.
module frequency_result_reader #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 10,
    parameter int BASE_ADDRESS         = 0,
    parameter int REGISTERS_NUMBER     = 6,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            irq,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] result_data,
    output logic [2:0]                      result_index,
    output logic                            result_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic                            timeout
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      index_q, index_d;
    logic                            irq_q;
    logic [C_M00_AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]                      rindex_q, rindex_d;
    logic                            rvalid_q, rvalid_d;
    logic                            error_q, error_d;
    logic                            timeout_q, timeout_d;
    logic                            irq_rise;
    logic                            last_reg;
    logic                            wdog_hit;

    assign irq_rise = irq & ~irq_q;
    assign last_reg = (index_q == 3'(REGISTERS_NUMBER - 1));

`ifdef FREQUENCY_RESULT_READER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;

    // Restarts on every state change, so each ADDR and DATA phase gets a full budget.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            wdog_cnt_d = '0;
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end

    assign wdog_hit = (wdog_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                      ((state_q == ST_ADDR) || (state_q == ST_DATA));
`else
    logic [31:0] timeout_cfg_unused;
    assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign wdog_hit           = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        data_d    = data_q;
        rindex_d  = rindex_q;
        rvalid_d  = 1'b0;
        error_d   = error_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (irq_rise) begin
                    state_d   = ST_ADDR;
                    index_d   = 3'd0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_ADDR: begin
                if (m00_axi_arready) begin
                    state_d = ST_DATA;
                end else if (wdog_hit) begin
                    state_d   = ST_DONE;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (m00_axi_rvalid) begin
                    data_d   = m00_axi_rdata;
                    rindex_d = index_q;
                    rvalid_d = 1'b1;
                    if (m00_axi_rresp != 2'b00) begin
                        error_d = 1'b1;
                    end
                    if (last_reg) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 3'd1;
                        state_d = ST_ADDR;
                    end
                end else if (wdog_hit) begin
                    state_d   = ST_DONE;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q   <= ST_IDLE;
            index_q   <= 3'd0;
            irq_q     <= 1'b0;
            data_q    <= '0;
            rindex_q  <= 3'd0;
            rvalid_q  <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            irq_q     <= irq;
            data_q    <= data_d;
            rindex_q  <= rindex_d;
            rvalid_q  <= rvalid_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    // Handshake controls are decoded from state, so a reset drops them at once.
    assign m00_axi_arvalid = (state_q == ST_ADDR);
    assign m00_axi_rready  = (state_q == ST_DATA);
    assign m00_axi_araddr  = (state_q == ST_ADDR) ?
                             C_M00_AXI_ADDR_WIDTH'(BASE_ADDRESS + 4 * int'(index_q)) : '0;
    assign m00_axi_arprot  = 3'b000;
    assign result_data     = data_q;
    assign result_index    = rindex_q;
    assign result_valid    = rvalid_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign error           = error_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_frequency_result_reader.sv
// Directed bench for frequency_result_reader with a small AXI4-Lite read slave model.
// Build with FREQUENCY_RESULT_READER_TIMEOUT_EN defined to exercise the watchdog expectations.
module tb_frequency_result_reader;
    logic        clk;
    logic        rst_n;
    logic        irq;
    logic [9:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] result_data;
    logic [2:0]  result_index;
    logic        result_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic        timeout;

    int n_vec = 0;
    int n_bad = 0;

    // slave configuration, written only by the stimulus process
    int   ar_delay = 0;
    int   bad_idx  = 7;
    logic r_never  = 1'b0;

    // observations, written only by the slave/monitor process
    int          n_res        = 0;
    int          n_ar         = 0;
    int          hold_viol    = 0;
    int          overlap_viol = 0;
    logic [31:0] res_data [256];
    logic [2:0]  res_idx  [256];
    logic [9:0]  ar_log   [256];

    frequency_result_reader #(
        .C_M00_AXI_DATA_WIDTH(32),
        .C_M00_AXI_ADDR_WIDTH(10),
        .BASE_ADDRESS        (0),
        .REGISTERS_NUMBER    (6),
        .TIMEOUT_CYCLES      (16)
    ) dut (
        .m00_axi_aclk   (clk),
        .m00_axi_aresetn(rst_n),
        .irq            (irq),
        .m00_axi_araddr (araddr),
        .m00_axi_arprot (arprot),
        .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata  (rdata),
        .m00_axi_rresp  (rresp),
        .m00_axi_rvalid (rvalid),
        .m00_axi_rready (rready),
        .result_data    (result_data),
        .result_index   (result_index),
        .result_valid   (result_valid),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .timeout        (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Slave model and monitor; everything here happens on the falling edge.
    initial begin
        logic       ar_pv;
        logic       r_pr;
        logic       hs;
        logic [9:0] ar_pa;
        int         ar_wait;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        ar_pv = 1'b0; r_pr = 1'b0; ar_pa = '0; ar_wait = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0;
                ar_pv = 1'b0; r_pr = 1'b0; ar_wait = 0;
            end else begin
                hs = arready && ar_pv;
                if (rvalid && r_pr) rvalid = 1'b0;
                if (hs) begin
                    arready = 1'b0;
                    ar_wait = 0;
                    rvalid  = !r_never;
                    rdata   = 32'd33 + 32'(ar_pa >> 2);
                    rresp   = (int'(ar_pa >> 2) == bad_idx) ? 2'b10 : 2'b00;
                end else if (arvalid) begin
                    if (ar_wait >= ar_delay) arready = 1'b1;
                    else ar_wait++;
                end
                if (result_valid && n_res < 256) begin
                    res_data[n_res] = result_data;
                    res_idx[n_res]  = result_index;
                    n_res++;
                end
                if (arvalid && arready && n_ar < 256) begin
                    ar_log[n_ar] = araddr;
                    n_ar++;
                end
                if (arvalid && ar_pv && araddr != ar_pa) hold_viol++;
                if (ar_pv && !hs && !arvalid) hold_viol++;
                if (arvalid && rready) overlap_viol++;
                ar_pv = arvalid;
                ar_pa = araddr;
                r_pr  = rready;
            end
        end
    end

    // mode 0: one-cycle irq pulse; 1: extra pulse while busy; 2: irq held high
    task automatic run_sweep(input int mode, output int done_at, output int n_dn,
                             output logic err_at, output logic tmo_at);
        done_at = -1; n_dn = 0; err_at = 1'b0; tmo_at = 1'b0;
        irq = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (mode == 0 && k == 1) irq = 1'b0;
            if (mode == 1) irq = (k == 5);
            if (mode == 2 && k == 50) irq = 1'b0;
            if (done) begin
                n_dn++;
                if (done_at < 0) begin
                    done_at = k;
                    err_at  = error;
                    tmo_at  = timeout;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_results(input string pfx, input int r0, input int a0);
        check_val({pfx, " strobes"}, 32'(n_res - r0), 32'd6);
        check_val({pfx, " ar count"}, 32'(n_ar - a0), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("%s data%0d", pfx, i), res_data[r0 + i], 32'(33 + i));
            check_val($sformatf("%s idx%0d", pfx, i), 32'(res_idx[r0 + i]), 32'(i));
            check_val($sformatf("%s addr%0d", pfx, i), 32'(ar_log[a0 + i]), 32'(4 * i));
        end
    endtask

    initial begin
        int   d_at, n_dn, r0, a0, nd;
        logic e_at, t_at;
        rst_n = 1'b0; irq = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst arvalid", 32'(arvalid), 32'd0);
        check_val("rst rready", 32'(rready), 32'd0);
        check_val("rst araddr", 32'(araddr), 32'd0);
        check_val("rst arprot", 32'(arprot), 32'd0);
        check_val("rst rdata", result_data, 32'd0);
        check_val("rst rindex", 32'(result_index), 32'd0);
        check_val("rst rvalid", 32'(result_valid), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst error", 32'(error), 32'd0);
        check_val("rst timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // nominal sweep, zero-wait slave
        r0 = n_res; a0 = n_ar;
        run_sweep(0, d_at, n_dn, e_at, t_at);
        check_val("t1 done cycle", 32'(d_at), 32'd13);
        check_val("t1 done count", 32'(n_dn), 32'd1);
        check_val("t1 error", 32'(e_at), 32'd0);
        check_val("t1 busy after", 32'(busy), 32'd0);
        check_results("t1", r0, a0);

        // slow arready: address must be held
        ar_delay = 3;
        r0 = n_res; a0 = n_ar;
        run_sweep(0, d_at, n_dn, e_at, t_at);
        check_val("t2 done cycle", 32'(d_at), 32'd31);
        check_results("t2", r0, a0);
        ar_delay = 0;

        // SLVERR on index 2
        bad_idx = 2;
        r0 = n_res; a0 = n_ar;
        run_sweep(0, d_at, n_dn, e_at, t_at);
        check_val("t3 error at done", 32'(e_at), 32'd1);
        check_val("t3 error sticky", 32'(error), 32'd1);
        check_results("t3", r0, a0);
        bad_idx = 7;
        run_sweep(0, d_at, n_dn, e_at, t_at);
        check_val("t3 error cleared", 32'(e_at), 32'd0);

        // second edge while busy, then level-high irq
        r0 = n_res;
        run_sweep(1, d_at, n_dn, e_at, t_at);
        check_val("t4 done count", 32'(n_dn), 32'd1);
        check_val("t4 strobes", 32'(n_res - r0), 32'd6);
        run_sweep(2, d_at, n_dn, e_at, t_at);
        check_val("t4 level done cnt", 32'(n_dn), 32'd1);
        check_val("t4 level done cyc", 32'(d_at), 32'd13);

        // reset while reading index 3
        r0 = n_res;
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        repeat (7) @(negedge clk);
        check_val("t5 rready pre", 32'(rready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5 arvalid rst", 32'(arvalid), 32'd0);
        check_val("t5 rready rst", 32'(rready), 32'd0);
        check_val("t5 busy rst", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check_val("t5 no done", 32'(nd), 32'd0);
        check_val("t5 strobes", 32'(n_res - r0), 32'd3);
        r0 = n_res; a0 = n_ar;
        run_sweep(0, d_at, n_dn, e_at, t_at);
        check_val("t5 restart done", 32'(d_at), 32'd13);
        check_results("t5", r0, a0);

        check_val("hold violations", 32'(hold_viol), 32'd0);
        check_val("ar/r overlap", 32'(overlap_viol), 32'd0);

        // read data never returned
        r_never = 1'b1;
        run_sweep(0, d_at, n_dn, e_at, t_at);
`ifdef FREQUENCY_RESULT_READER_TIMEOUT_EN
        check_val("t6 done cycle", 32'(d_at), 32'd18);
        check_val("t6 done count", 32'(n_dn), 32'd1);
        check_val("t6 error", 32'(e_at), 32'd1);
        check_val("t6 timeout", 32'(t_at), 32'd1);
`else
        check_val("t6 done count", 32'(n_dn), 32'd0);
        check_val("t6 busy", 32'(busy), 32'd1);
        check_val("t6 rready", 32'(rready), 32'd1);
        check_val("t6 timeout", 32'(timeout), 32'd0);
`endif
        rst_n = 1'b0;
        r_never = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frequency_result_reader.md
FREQUENCY_RESULT_READER -- requirements
Module: frequency_result_reader

Interface
REQ-001 SHALL have parameter C_M00_AXI_DATA_WIDTH, default 32, AXI read data width (only 32 supported).
REQ-002 SHALL have parameter C_M00_AXI_ADDR_WIDTH, default 10, AXI address width.
REQ-003 SHALL have parameter BASE_ADDRESS, default 0, byte address of result register 0.
REQ-004 SHALL have parameter REGISTERS_NUMBER, default 6, result registers per sweep (1..8).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit (used only with macro, REQ-030).
REQ-006 Clock: single clock m00_axi_aclk; reset: m00_axi_aresetn, asynchronous, active-low; all logic on m00_axi_aclk.
REQ-007 Ports: m00_axi_aclk in 1 clock; m00_axi_aresetn in 1 async active-low reset.
REQ-008 Ports: irq in 1 results-ready request (synchronous to m00_axi_aclk).
REQ-009 Ports: m00_axi_araddr out ADDR_WIDTH; m00_axi_arprot out 3 (constant 0); m00_axi_arvalid out 1; m00_axi_arready in 1.
REQ-010 Ports: m00_axi_rdata in 32; m00_axi_rresp in 2; m00_axi_rvalid in 1; m00_axi_rready out 1.
REQ-011 Ports: result_data out 32; result_index out 3; result_valid out 1 (one-cycle strobe).
REQ-012 Ports: busy out 1; done out 1 (one-cycle strobe); error out 1 (sticky per sweep); timeout out 1.

Function
REQ-013 FSM states IDLE, ADDR, DATA, DONE; reset state IDLE.
REQ-014 IDLE: sweep starts on irq rising edge (irq=1 this cycle, registered irq_d=0); index<=0, next state ADDR, error<=0, timeout<=0.
REQ-015 irq rising edges while not IDLE SHALL be ignored; level-high irq SHALL not retrigger.
REQ-016 ADDR: arvalid=1, araddr=BASE_ADDRESS+4*index, both stable until arready; on arvalid&&arready -> DATA.
REQ-017 DATA: rready=1; on rvalid&&rready capture rdata into result_data, index into result_index, pulse result_valid next cycle.
REQ-018 DATA: rresp!=2'b00 on accepted beat SHALL set error; data still reported.
REQ-019 DATA accept: index==REGISTERS_NUMBER-1 -> DONE, else index+1 -> ADDR.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 busy=1 in ADDR, DATA, DONE; 0 in IDLE.
REQ-022 At most one outstanding read; arvalid and rready never high in same cycle.
REQ-023 Latency with arready=1 and rvalid one cycle after AR handshake: arvalid rises 1 cycle after irq edge; each register 2 cycles; done 2*REGISTERS_NUMBER+1 cycles after irq edge.
REQ-024 result_data/result_index hold last value until next accepted beat.

Reset
REQ-025 Reset SHALL asynchronously force IDLE, index 0, irq_d 0.
REQ-026 Reset values: arvalid 0, rready 0, araddr 0, arprot 0, result_data 0, result_index 0, result_valid 0, busy 0, done 0, error 0, timeout 0.
REQ-027 Reset mid-sweep SHALL abandon the sweep without done/result_valid; post-reset irq high is not an edge (irq_d reset 0 -> edge only if irq sampled high after reset, treated as new sweep).

Configuration
REQ-028 Macro FREQUENCY_RESULT_READER_TIMEOUT_EN selects the watchdog.
REQ-029 Without macro: ADDR/DATA wait indefinitely; timeout output tied 0.
REQ-030 With macro: counter clears on entry to ADDR and DATA, increments each cycle there; reaching TIMEOUT_CYCLES forces arvalid=0, rready=0, error=1, timeout=1, state DONE (done pulse still issued).

Verification
REQ-031 arready=1, rvalid 1 cycle after AR, rdata=33+i, rresp=0: irq pulse -> 6 result_valid strobes, index 0..5, data 33..38, araddr 0,4,..,20, done at cycle 13, error 0.
REQ-032 arready delayed 3 cycles per read -> arvalid/araddr held stable until handshake; data order unchanged.
REQ-033 rresp=2'b10 on index 2 -> error=1 at done, all six result_valid strobes still emitted; next sweep clears error.
REQ-034 Second irq edge during busy -> ignored; exactly one done pulse.
REQ-035 Reset asserted while in DATA at index 3 -> arvalid/rready/busy 0 immediately, no done; new irq edge restarts at index 0.
REQ-036 With FREQUENCY_RESULT_READER_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid never asserted -> timeout=1, error=1, done pulse 16 cycles after DATA entry; without macro, busy stays 1.
